// File: rtl/unary_operand_sequencer.sv
// Serialises two binary operands into thermometer-coded unary streams and sequences the adder.
// Optional range_err output is enabled by defining UNARY_SEQ_RANGE_ERR_EN.
module unary_operand_sequencer #(
    parameter int unsigned SLOTS = 16,
    parameter int unsigned OP_W  = 5,
    parameter int unsigned DRAIN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] a_val,
    input  logic [OP_W-1:0] b_val,
    output logic            busy,
    output logic            done,
    output logic            A,
    output logic            B,
    output logic            en,
`ifdef UNARY_SEQ_RANGE_ERR_EN
    output logic            range_err,
`endif
    output logic            read_or_write
);

    localparam int unsigned MAX_PHASE = (SLOTS > DRAIN) ? SLOTS : DRAIN;
    localparam int unsigned CW        = $clog2(MAX_PHASE) + 1;
    localparam int unsigned CMP_W     = (CW > OP_W) ? CW : OP_W;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StFlush,
        StWrite,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0] a_lat_q, a_lat_d;
    logic [OP_W-1:0] b_lat_q, b_lat_d;
    logic            busy_d, done_d, a_d, b_d, en_d, rw_d;
    logic            op_over;

    assign op_over = (a_val > OP_W'(SLOTS)) || (b_val > OP_W'(SLOTS));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_lat_d = a_lat_q;
        b_lat_d = b_lat_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_lat_d = (a_val > OP_W'(SLOTS)) ? OP_W'(SLOTS) : a_val;
                    b_lat_d = (b_val > OP_W'(SLOTS)) ? OP_W'(SLOTS) : b_val;
                    cnt_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (cnt_q == CW'(SLOTS - 1)) begin
                    cnt_d   = '0;
                    state_d = StFlush;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StFlush: begin
                cnt_d   = '0;
                state_d = StWrite;
            end
            StWrite: begin
                if (cnt_q == CW'(DRAIN - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered values line up with it.
    always_comb begin
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
        en_d   = (state_d == StRead) || (state_d == StFlush) || (state_d == StWrite);
        rw_d   = (state_d == StWrite);
        a_d    = (state_d == StRead) && (CMP_W'(cnt_d) < CMP_W'(a_lat_d));
        b_d    = (state_d == StRead) && (CMP_W'(cnt_d) < CMP_W'(b_lat_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            a_lat_q       <= '0;
            b_lat_q       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            A             <= 1'b0;
            B             <= 1'b0;
            en            <= 1'b0;
            read_or_write <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            a_lat_q       <= a_lat_d;
            b_lat_q       <= b_lat_d;
            busy          <= busy_d;
            done          <= done_d;
            A             <= a_d;
            B             <= b_d;
            en            <= en_d;
            read_or_write <= rw_d;
        end
    end

`ifdef UNARY_SEQ_RANGE_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            range_err <= 1'b0;
        end else if (state_q == StIdle && start) begin
            range_err <= op_over;
        end
    end
`else
    logic unused_op_over;
    assign unused_op_over = op_over;
`endif

endmodule

// File: tb/tb_unary_operand_sequencer.sv
// Randomised self-checking bench; expected outputs come from a cycles-since-accept model.
module tb_unary_operand_sequencer;

    localparam int SLOTS = 16;
    localparam int OP_W  = 5;
    localparam int DRAIN = 32;
    localparam int LAST  = SLOTS + DRAIN + 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [OP_W-1:0] a_val = '0;
    logic [OP_W-1:0] b_val = '0;
    logic            busy, done, A, B, en, read_or_write;
`ifdef UNARY_SEQ_RANGE_ERR_EN
    logic            range_err;
`endif

    int checks = 0;
    int failures = 0;

    unary_operand_sequencer #(
        .SLOTS(SLOTS),
        .OP_W (OP_W),
        .DRAIN(DRAIN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a_val        (a_val),
        .b_val        (b_val),
        .busy         (busy),
        .done         (done),
        .A            (A),
        .B            (B),
        .en           (en),
`ifdef UNARY_SEQ_RANGE_ERR_EN
        .range_err    (range_err),
`endif
        .read_or_write(read_or_write)
    );

    always #5 clk = ~clk;

    // Model: n = cycles since the accepting edge (0 = idle), plus clamped operands.
    int   n = 0;
    int   ma = 0;
    int   mb = 0;
    logic m_rerr = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n      <= 0;
            ma     <= 0;
            mb     <= 0;
            m_rerr <= 1'b0;
        end else if (n >= 1 && n < LAST) begin
            n <= n + 1;
        end else if (n == LAST) begin
            n <= 0;
        end else if (start) begin
            n      <= 1;
            ma     <= (int'(a_val) > SLOTS) ? SLOTS : int'(a_val);
            mb     <= (int'(b_val) > SLOTS) ? SLOTS : int'(b_val);
            m_rerr <= (int'(a_val) > SLOTS) || (int'(b_val) > SLOTS);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d n=%0d t=%0t", tag, got, exp, n, $time);
        end
    endtask

    task automatic check_all();
        check_eq("busy", 32'(busy), 32'(n != 0));
        check_eq("done", 32'(done), 32'(n == LAST));
        check_eq("en", 32'(en), 32'(n >= 1 && n <= SLOTS + DRAIN + 1));
        check_eq("rw", 32'(read_or_write), 32'(n >= SLOTS + 2 && n <= SLOTS + DRAIN + 1));
        check_eq("A", 32'(A), 32'(n >= 1 && n <= SLOTS && n <= ma));
        check_eq("B", 32'(B), 32'(n >= 1 && n <= SLOTS && n <= mb));
`ifdef UNARY_SEQ_RANGE_ERR_EN
        check_eq("range_err", 32'(range_err), 32'(m_rerr));
`endif
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_txn(input int a, input int b);
        a_val = OP_W'(a);
        b_val = OP_W'(b);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (LAST + 2) cycle();
    endtask

    initial begin
        int ones;
        // Reset state
        #1;
        check_all();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (10) cycle();

        run_txn(3, 5);
        run_txn(16, 16);
        run_txn(0, 0);
        run_txn(20, 2);

        // start during READ must be ignored
        a_val = 5'd7;
        b_val = 5'd9;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (9) cycle();
        a_val = 5'd1;
        b_val = 5'd15;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (LAST) cycle();

        // Reset in WRITE, then restart with start held through release
        a_val = 5'd12;
        b_val = 5'd6;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (19) cycle();
        rst_n = 1'b0;
        #1;
        check_all();
        a_val = 5'd11;
        b_val = 5'd4;
        start = 1'b1;
        #1;
        rst_n = 1'b1;
        cycle();
        start = 1'b0;
        repeat (LAST + 1) cycle();

        // start held high: back-to-back sequences, counting DONE pulses
        ones = 0;
        a_val = 5'd10;
        b_val = 5'd16;
        start = 1'b1;
        repeat (2 * (LAST + 1)) begin
            cycle();
            if (done) ones++;
        end
        start = 1'b0;
        check_eq("b2b_done_count", 32'(ones), 32'd2);
        repeat (LAST + 2) cycle();

        // Random stimulus with occasional resets
        repeat (3000) begin
            a_val = OP_W'($urandom);
            b_val = OP_W'($urandom_range(0, SLOTS + 2));
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                check_all();
                #1;
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
